// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register built as a two-entry skid buffer with valid/ready on both sides.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int                 CTRL_W   = 12,
    parameter int                 DATA_W   = 186,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter logic [DATA_W-1:0]  DATA_NOP = '0,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              accept;
    logic              drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = main_v_q & out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || drain) begin
            if (skid_v_q) begin
                // Skid entry is older than anything at the input, so it moves up first.
                main_v_d    = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_v_d    = accept;
                if (accept) begin
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end
            end else if (accept) begin
                main_v_d    = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
        end

        // An empty main entry always carries the NOP pattern, so outputs come straight from flops.
        if (!main_v_d) begin
            main_ctrl_d = CTRL_NOP;
            main_data_d = DATA_NOP;
        end

        in_ready_d = !skid_v_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= CTRL_NOP;
            main_data_q <= DATA_NOP;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    // NOTE: skid payload has no reset; it is only observed when skid_v_q is set.
    always_ff @(posedge clk) begin
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush leaves them untouched.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_v_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!main_v_q && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

    a_skid_implies_main: assert property (@(posedge clk) disable iff (rst) skid_v_q |-> main_v_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, counter sequence, and random traffic against a queue model.
// Counter expectations follow PIPE_STAGE_PERF_EN when it is defined.
module tb_pipe_stage_skid;

    localparam int CW = 12;
    localparam int DW = 186;
    localparam int NW = 4;
    localparam logic [CW-1:0] CNOP = 12'h5A3;
    localparam logic [DW-1:0] DNOP = {62{3'b101}};
    localparam logic [CW-1:0] A = 12'h00A, B = 12'h00B, C = 12'h00C, D = 12'h00D;

    logic          clk;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] stall_cnt, bubble_cnt;

    pipe_stage_skid #(
        .CTRL_W(CW), .DATA_W(DW), .CTRL_NOP(CNOP), .DATA_NOP(DNOP), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string         name;
        logic          rst;
        logic          flush;
        logic          in_valid;
        logic          out_ready;
        logic [CW-1:0] ctrl;
        logic          exp_valid;
        logic          exp_ready;
        logic [CW-1:0] exp_ctrl;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stage is a FIFO of depth 2 whose head is what the outputs show.
    logic [CW-1:0] mq_ctrl[$];
    logic [DW-1:0] mq_data[$];
    int m_stall  = 0;
    int m_bubble = 0;

    function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
        return {c[5:0], {15{c}}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic f, input logic iv, input logic orr,
                       input logic [CW-1:0] c, input logic ev, input logic er, input logic [CW-1:0] ec);
        vec_t v;
        v.name = name; v.rst = r; v.flush = f; v.in_valid = iv; v.out_ready = orr; v.ctrl = c;
        v.exp_valid = ev; v.exp_ready = er; v.exp_ctrl = ev ? ec : CNOP;
        vecs.push_back(v);
    endtask

    // Drive one cycle, advance the model, then compare everything just after the edge.
    task automatic step(input logic r, input logic f, input logic iv, input logic orr,
                        input logic [CW-1:0] c, input logic [DW-1:0] d);
        bit pre_ready;
        bit pre_valid;
        logic [NW-1:0] e_stall;
        logic [NW-1:0] e_bubble;
        rst = r; flush = f; in_valid = iv; out_ready = orr; in_ctrl = c; in_data = d;
        @(posedge clk);
        pre_ready = (mq_ctrl.size() < 2);
        pre_valid = (mq_ctrl.size() > 0);
        if (r) begin
            mq_ctrl.delete(); mq_data.delete();
            m_stall = 0; m_bubble = 0;
        end else begin
            if (pre_valid && !orr && m_stall < 15) m_stall++;
            if (!pre_valid && m_bubble < 15) m_bubble++;
            if (f) begin
                mq_ctrl.delete(); mq_data.delete();
            end else begin
                if (pre_valid && orr) begin
                    void'(mq_ctrl.pop_front());
                    void'(mq_data.pop_front());
                end
                if (iv && pre_ready) begin
                    mq_ctrl.push_back(c);
                    mq_data.push_back(d);
                end
            end
        end
        #1;
        check("model_out_valid", DW'(out_valid), DW'(mq_ctrl.size() > 0));
        check("model_in_ready", DW'(in_ready), DW'(mq_ctrl.size() < 2));
        check("model_out_ctrl", DW'(out_ctrl), DW'((mq_ctrl.size() > 0) ? mq_ctrl[0] : CNOP));
        check("model_out_data", out_data, (mq_data.size() > 0) ? mq_data[0] : DNOP);
`ifdef PIPE_STAGE_PERF_EN
        e_stall  = NW'(m_stall);
        e_bubble = NW'(m_bubble);
`else
        e_stall  = '0;
        e_bubble = '0;
`endif
        check("model_stall_cnt", DW'(stall_cnt), DW'(e_stall));
        check("model_bubble_cnt", DW'(bubble_cnt), DW'(e_bubble));
    endtask

    initial begin
        logic [191:0] rnd;
        logic [NW-1:0] exp_sat;
        logic [NW-1:0] exp_bub;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_ctrl = '0; in_data = '0;

        //   name         rst flush iv  ordy ctrl  exp_v rdy exp_ctrl
        add("reset0",     1, 0, 1, 1, A,   0, 1, CNOP);
        add("reset1",     1, 0, 1, 1, A,   0, 1, CNOP);
        add("strm_a",     0, 0, 1, 1, A,   1, 1, A);
        add("strm_b",     0, 0, 1, 1, B,   1, 1, B);
        add("strm_c",     0, 0, 1, 1, C,   1, 1, C);
        add("strm_end",   0, 0, 0, 1, D,   0, 1, CNOP);
        add("stl_a",      0, 0, 1, 0, A,   1, 1, A);
        add("stl_b",      0, 0, 1, 0, B,   1, 0, A);
        add("stl_c0",     0, 0, 1, 0, C,   1, 0, A);
        add("stl_c1",     0, 0, 1, 0, C,   1, 0, A);
        add("stl_c2",     0, 0, 1, 0, C,   1, 0, A);
        add("stl_c3",     0, 0, 1, 0, C,   1, 0, A);
        add("rel_b",      0, 0, 1, 1, C,   1, 1, B);
        add("rel_c",      0, 0, 1, 1, C,   1, 1, C);
        add("rel_end",    0, 0, 0, 1, C,   0, 1, CNOP);
        add("fl_fill_a",  0, 0, 1, 0, A,   1, 1, A);
        add("fl_fill_b",  0, 0, 1, 0, B,   1, 0, A);
        add("fl_d",       0, 1, 1, 0, D,   0, 1, CNOP);
        add("fl_after",   0, 0, 0, 1, D,   0, 1, CNOP);
        add("fd_a",       0, 0, 1, 1, A,   1, 1, A);
        add("fd_flush",   0, 1, 0, 1, A,   0, 1, CNOP);
        add("fd_bubble",  0, 0, 0, 1, A,   0, 1, CNOP);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
                 vecs[i].ctrl, data_of(vecs[i].ctrl));
            check({vecs[i].name, "_valid"}, DW'(out_valid), DW'(vecs[i].exp_valid));
            check({vecs[i].name, "_ready"}, DW'(in_ready), DW'(vecs[i].exp_ready));
            check({vecs[i].name, "_ctrl"}, DW'(out_ctrl), DW'(vecs[i].exp_ctrl));
            check({vecs[i].name, "_data"}, out_data, vecs[i].exp_valid ? data_of(vecs[i].exp_ctrl) : DNOP);
        end

        // Counter saturation: one bubble cycle, then main held full for 20 stalled cycles.
        step(1, 0, 0, 1, '0, '0);
        step(0, 0, 1, 0, A, data_of(A));
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, '0, '0);
`ifdef PIPE_STAGE_PERF_EN
        exp_sat = 4'hF;
        exp_bub = 4'h1;
`else
        exp_sat = 4'h0;
        exp_bub = 4'h0;
`endif
        check("sat_stall_cnt", DW'(stall_cnt), DW'(exp_sat));
        check("sat_bubble_cnt", DW'(bubble_cnt), DW'(exp_bub));
        check("sat_hold_data", out_data, data_of(A));
        step(1, 0, 0, 1, '0, '0);
        check("sat_rst_stall", DW'(stall_cnt), '0);
        check("sat_rst_bubble", DW'(bubble_cnt), '0);

        // Random traffic against the FIFO model.
        for (int k = 0; k < 4000; k++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 rnd[191:180], rnd[DW-1:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
